clock_display_driver: RTL and testbench
=======================================

# clock_display_driver

Reader side of the game countdown clock: consumes the minute, tens-of-seconds and seconds digit values and drives a 4-digit common-anode seven-segment display as M:SS. It captures the digit values once per frame so a scan never shows a mix of two values, blanks between digit slots to prevent ghosting, and flags and flashes time-up. It sits between the countdown clock and the board display pins.

## Interface
- REFRESH_DIV, 100000: clk cycles per digit slot; must be at least 4.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off; must be less than REFRESH_DIV.
- FLASH_DIV, 50000000: clk cycles per flash phase.
- clk  in  1  system clock, 100 MHz.
- reset  in  1  reset, synchronous, active-high.
- m  in  32  minutes digit, unsigned.
- s10  in  32  tens-of-seconds digit, unsigned.
- s1  in  32  seconds digit, unsigned.
- an  out  4  anodes, active-low; an[3] is leftmost.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low; used as the colon.
- time_up  out  1  high while the captured time is 0:00.

## Operation
- Slot FSM with states DIG0, DIG1, DIG2 and DIG3, cycling in that order.
  - Slot counter runs 0..REFRESH_DIV-1.
  - The state advances on the cycle the counter equals REFRESH_DIV-1; DIG3 wraps to DIG0.
- Capture:
  - m, s10 and s1 are registered into the snapshot on the DIG3→DIG0 advance.
  - They are also registered on the first cycle after reset deasserts.
  - The snapshot valid flag sets at that first capture.
- Digit mapping:
  - DIG0 shows s1 and drives an[0].
  - DIG1 shows s10 and drives an[1].
  - DIG2 shows m and drives an[2]; dp=0 in this slot, 1 in all others.
  - DIG3 drives an[3]: blank (seg=7'h7F) when m≤9, dash when m>9.
- Range check:
  - s1>9, s10>5 or m>9 displays as a dash (7'b0111111).
  - Comparisons use the full 32 bits, so any value with bits above bit 3 set is out of range.
- Encoding (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- time_up = valid & (snapshot m, s10 and s1 all zero). It updates only at a capture.
- Flash counter runs 0..FLASH_DIV-1 and toggles the flash phase at the terminal count. Both clear when time_up rises.

## Timing
- Reset values:
  - an=4'b1111, seg=7'h7F, dp=1, time_up=0
  - state=DIG0, slot and flash counters=0, valid=0, snapshot=0
- All outputs are registered.
  - an, seg and dp reflect the state and counter of the previous cycle.
  - The first lit anode appears at cycle BLANK_CYCLES+1 after reset release.
- Blanking: while the slot counter is below BLANK_CYCLES, an=4'b1111 and dp=1. seg may change during blanking.
- Input changes mid-frame have no effect until the next DIG3→DIG0 capture.
- Worst-case display latency is 4·REFRESH_DIV+1 cycles.
- Reset asserted mid-slot returns every output to its reset value on the next clk edge, with no partial frame.
- If a capture and a flash terminal count fall on the same cycle, both take effect. time_up rising takes priority: the flash phase is forced to ON.

## Configuration
- CLOCK_DISP_FLASH_EN defined:
  - While time_up=1, the flash OFF phase forces an=4'b1111.
  - The ON phase shows 0:00.
- CLOCK_DISP_FLASH_EN undefined:
  - The flash counter is not built.
  - 0:00 displays steadily; time_up behaves identically.

## Test plan
Bench parameters: REFRESH_DIV=8, BLANK_CYCLES=2, FLASH_DIV=64.
- Reset held, then released with m=2, s10=0, s1=0:
  - an=1111 and seg=7F for 3 cycles.
  - DIG0 then shows an=1110, seg=1000000.
  - DIG2 shows an=1011, seg=0100100, dp=0.
  - DIG3 shows an=0111, seg=7F.
- m=1, s10=3, s1=7 set mid-frame:
  - The old value holds until the DIG3→DIG0 advance.
  - The next frame shows 7 / 3 / 1 patterns (1111000 / 0110000 / 1111001).
- s1=12, s10=6, m=15:
  - DIG0, DIG1 and DIG2 show dash 0111111.
  - DIG3 shows dash with an[3]=0.
- Inputs set to 0/0/0:
  - time_up rises at the next capture.
  - With CLOCK_DISP_FLASH_EN, an stays 1111 for 64-cycle OFF phases alternating with 64-cycle 0:00 phases.
  - Without the macro, the display stays steady.
- Reset asserted for 1 cycle while in DIG2 with a lit anode: the next cycle shows an=1111, time_up=0, and the FSM is in DIG0.
- s1=32'h0000_0013: displays dash, not 3.

Source files
------------

// File: rtl/clock_display_driver.sv
// Seven-segment M:SS display driver for the countdown clock: frame-synchronous digit capture, anti-ghost blanking, time-up flag.
// Optional time-up flashing is enabled by defining CLOCK_DISP_FLASH_EN.
module clock_display_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int FLASH_DIV    = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m,
  input  logic [31:0] s10,
  input  logic [31:0] s1,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        time_up
);

  localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] BLANK_END = SW'(BLANK_CYCLES);
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {DIG0 = 2'd0, DIG1 = 2'd1, DIG2 = 2'd2, DIG3 = 2'd3} slot_state_t;

  slot_state_t   state_r;
  slot_state_t   state_next_s;
  logic [SW-1:0] slot_cnt_r;
  logic          slot_last_s;
  logic          first_r;
  logic          capture_s;
  logic          zero_in_s;
  logic          valid_r;
  logic [31:0]   snap_m_r;
  logic [31:0]   snap_s10_r;
  logic [31:0]   snap_s1_r;
  logic          time_up_r;
  logic          dark_s;
  logic [3:0]    an_s;
  logic [6:0]    seg_s;
  logic          dp_s;
  logic [3:0]    an_r;
  logic [6:0]    seg_r;
  logic          dp_r;

  // Out-of-range values (full 32-bit compare) render as a dash.
  function automatic logic [6:0] digit_seg(input logic [31:0] v, input logic [31:0] max_v);
    logic [6:0] r;
    if (v > max_v) begin
      r = SEG_DASH;
    end else begin
      case (v[3:0])
        4'd0:    r = 7'b1000000;
        4'd1:    r = 7'b1111001;
        4'd2:    r = 7'b0100100;
        4'd3:    r = 7'b0110000;
        4'd4:    r = 7'b0011001;
        4'd5:    r = 7'b0010010;
        4'd6:    r = 7'b0000010;
        4'd7:    r = 7'b1111000;
        4'd8:    r = 7'b0000000;
        4'd9:    r = 7'b0010000;
        default: r = SEG_DASH;
      endcase
    end
    return r;
  endfunction

  assign slot_last_s = (slot_cnt_r == SLOT_LAST);
  assign capture_s   = first_r | ((state_r == DIG3) & slot_last_s);
  assign zero_in_s   = (m == 32'd0) && (s10 == 32'd0) && (s1 == 32'd0);

  // Slot FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= DIG0;
    else       state_r <= state_next_s;
  end

  // Slot FSM next state: advance on the last cycle of each slot.
  always_comb begin
    state_next_s = state_r;
    if (slot_last_s) begin
      case (state_r)
        DIG0:    state_next_s = DIG1;
        DIG1:    state_next_s = DIG2;
        DIG2:    state_next_s = DIG3;
        DIG3:    state_next_s = DIG0;
        default: state_next_s = DIG0;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Slot counter, post-reset capture marker and frame snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt_r <= '0;
      first_r    <= 1'b1;
      valid_r    <= 1'b0;
      snap_m_r   <= 32'd0;
      snap_s10_r <= 32'd0;
      snap_s1_r  <= 32'd0;
      time_up_r  <= 1'b0;
    end else begin
      first_r    <= 1'b0;
      slot_cnt_r <= slot_last_s ? '0 : slot_cnt_r + SW'(1);
      if (capture_s) begin
        valid_r    <= 1'b1;
        snap_m_r   <= m;
        snap_s10_r <= s10;
        snap_s1_r  <= s1;
        time_up_r  <= zero_in_s;
      end
    end
  end

`ifdef CLOCK_DISP_FLASH_EN
  localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);

  logic [FW-1:0] flash_cnt_r;
  logic          flash_off_r;
  logic          time_up_rise_s;

  assign time_up_rise_s = capture_s & zero_in_s & ~time_up_r;

  // Flash phase timer; a fresh time-up restarts it in the ON phase.
  always_ff @(posedge clk) begin
    if (reset || time_up_rise_s) begin
      flash_cnt_r <= '0;
      flash_off_r <= 1'b0;
    end else if (flash_cnt_r == FLASH_LAST) begin
      flash_cnt_r <= '0;
      flash_off_r <= ~flash_off_r;
    end else begin
      flash_cnt_r <= flash_cnt_r + FW'(1);
    end
  end

  assign dark_s = time_up_r & flash_off_r;
`else
  assign dark_s = 1'b0;
`endif

  // Output decode from the current slot, counter and snapshot.
  always_comb begin
    an_s  = 4'b1111;
    seg_s = SEG_BLANK;
    dp_s  = 1'b1;
    if ((slot_cnt_r < BLANK_END) || dark_s || !valid_r) begin
      an_s  = 4'b1111;
      seg_s = SEG_BLANK;
      dp_s  = 1'b1;
    end else begin
      case (state_r)
        DIG0: begin
          an_s  = 4'b1110;
          seg_s = digit_seg(snap_s1_r, 32'd9);
        end
        DIG1: begin
          an_s  = 4'b1101;
          seg_s = digit_seg(snap_s10_r, 32'd5);
        end
        DIG2: begin
          an_s  = 4'b1011;
          seg_s = digit_seg(snap_m_r, 32'd9);
          dp_s  = 1'b0;
        end
        DIG3: begin
          an_s  = 4'b0111;
          seg_s = (snap_m_r > 32'd9) ? SEG_DASH : SEG_BLANK;
        end
        default: begin
          an_s  = 4'b1111;
          seg_s = SEG_BLANK;
        end
      endcase
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_r  <= 4'b1111;
      seg_r <= SEG_BLANK;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= an_s;
      seg_r <= seg_s;
      dp_r  <= dp_s;
    end
  end

  assign an      = an_r;
  assign seg     = seg_r;
  assign dp      = dp_r;
  assign time_up = time_up_r;

endmodule

// File: tb/tb_clock_display_driver.sv
// Directed bench for clock_display_driver with REFRESH_DIV=8, BLANK_CYCLES=2, FLASH_DIV=64.
// Covers both builds; flash checks follow CLOCK_DISP_FLASH_EN.
module tb_clock_display_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] m = 32'd0;
  logic [31:0] s10 = 32'd0;
  logic [31:0] s1 = 32'd0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        time_up;

  int vectors = 0;
  int errors  = 0;
  int k = 0;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'h7F;
  localparam logic [6:0] SD = 7'b0111111;

  clock_display_driver #(
    .REFRESH_DIV(8),
    .BLANK_CYCLES(2),
    .FLASH_DIV(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .m(m),
    .s10(s10),
    .s1(s1),
    .an(an),
    .seg(seg),
    .dp(dp),
    .time_up(time_up)
  );

  always #5 clk = ~clk;

  // Advance one clock; sampling and driving happen on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask

  task automatic goto(input int t);
    while (k < t) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; m = 32'd2; s10 = 32'd0; s1 = 32'd0;
    repeat (3) tick();
    vectors++;
    if ({an, seg, dp, time_up} !== {4'b1111, SB, 1'b1, 1'b0})
      $display("FAIL reset_hold: got %b/%b/%b/%b want 1111/1111111/1/0", an, seg, dp, time_up);
    if ({an, seg, dp, time_up} !== {4'b1111, SB, 1'b1, 1'b0}) errors++;
    reset = 1'b0;
    k = 0;
    for (int i = 1; i <= 2; i++) begin
      tick();
      vectors++;
      if ({an, seg, dp} !== {4'b1111, SB, 1'b1}) begin
        errors++;
        $display("FAIL release_blank k=%0d: got %b/%b/%b want 1111/1111111/1", k, an, seg, dp);
      end
    end
    tick();
    vectors++;
    if ({an, seg, dp} !== {4'b1110, S0, 1'b1}) begin
      errors++;
      $display("FAIL first_dig0: got %b/%b/%b want 1110/%b/1", an, seg, dp, S0);
    end
    goto(11);
    vectors++;
    if ({an, seg, dp} !== {4'b1101, S0, 1'b1}) begin
      errors++;
      $display("FAIL dig1_zero: got %b/%b/%b want 1101/%b/1", an, seg, dp, S0);
    end
    goto(17);
    vectors++;
    if ({an, dp} !== {4'b1111, 1'b1}) begin
      errors++;
      $display("FAIL slot_blanking: got an=%b dp=%b want 1111/1", an, dp);
    end
    goto(19);
    vectors++;
    if ({an, seg, dp} !== {4'b1011, S2, 1'b0}) begin
      errors++;
      $display("FAIL dig2_two: got %b/%b/%b want 1011/%b/0", an, seg, dp, S2);
    end
  endtask

  task automatic test_mid_frame_hold();
    m = 32'd1; s10 = 32'd3; s1 = 32'd7;
    goto(21);
    vectors++;
    if ({an, seg, dp} !== {4'b1011, S2, 1'b0}) begin
      errors++;
      $display("FAIL hold_old_m: got %b/%b/%b want 1011/%b/0", an, seg, dp, S2);
    end
    goto(27);
    vectors++;
    if ({an, seg, dp, time_up} !== {4'b0111, SB, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL dig3_blank: got %b/%b/%b/%b want 0111/1111111/1/0", an, seg, dp, time_up);
    end
    goto(35);
    vectors++;
    if ({an, seg, dp} !== {4'b1110, S7, 1'b1}) begin
      errors++;
      $display("FAIL new_s1_7: got %b/%b/%b want 1110/%b/1", an, seg, dp, S7);
    end
    goto(43);
    vectors++;
    if ({an, seg, dp} !== {4'b1101, S3, 1'b1}) begin
      errors++;
      $display("FAIL new_s10_3: got %b/%b/%b want 1101/%b/1", an, seg, dp, S3);
    end
    goto(51);
    vectors++;
    if ({an, seg, dp} !== {4'b1011, S1, 1'b0}) begin
      errors++;
      $display("FAIL new_m_1: got %b/%b/%b want 1011/%b/0", an, seg, dp, S1);
    end
  endtask

  task automatic test_range();
    s1 = 32'd12; s10 = 32'd6; m = 32'd15;
    goto(67);
    vectors++;
    if ({an, seg} !== {4'b1110, SD}) begin
      errors++;
      $display("FAIL range_s1: got %b/%b want 1110/%b", an, seg, SD);
    end
    goto(75);
    vectors++;
    if ({an, seg} !== {4'b1101, SD}) begin
      errors++;
      $display("FAIL range_s10: got %b/%b want 1101/%b", an, seg, SD);
    end
    goto(83);
    vectors++;
    if ({an, seg, dp} !== {4'b1011, SD, 1'b0}) begin
      errors++;
      $display("FAIL range_m: got %b/%b/%b want 1011/%b/0", an, seg, dp, SD);
    end
    goto(91);
    vectors++;
    if ({an, seg, time_up} !== {4'b0111, SD, 1'b0}) begin
      errors++;
      $display("FAIL range_dig3: got %b/%b/%b want 0111/%b/0", an, seg, time_up, SD);
    end
  endtask

  task automatic test_high_bits();
    s1 = 32'h0000_0013; s10 = 32'd0; m = 32'd0;
    goto(99);
    vectors++;
    if ({an, seg} !== {4'b1110, SD}) begin
      errors++;
      $display("FAIL s1_0x13: got %b/%b want 1110/%b", an, seg, SD);
    end
    goto(115);
    vectors++;
    if ({an, seg, dp} !== {4'b1011, S0, 1'b0}) begin
      errors++;
      $display("FAIL m_zero: got %b/%b/%b want 1011/%b/0", an, seg, dp, S0);
    end
    goto(123);
    vectors++;
    if ({an, seg} !== {4'b0111, SB}) begin
      errors++;
      $display("FAIL dig3_m0: got %b/%b want 0111/1111111", an, seg);
    end
  endtask

  task automatic test_time_up();
    s1 = 32'd0; s10 = 32'd0; m = 32'd0;
    goto(127);
    vectors++;
    if (time_up !== 1'b0) begin
      errors++;
      $display("FAIL time_up_early: got %b want 0", time_up);
    end
    goto(128);
    vectors++;
    if (time_up !== 1'b1) begin
      errors++;
      $display("FAIL time_up_rise: got %b want 1", time_up);
    end
    goto(131);
    vectors++;
    if ({an, seg, dp} !== {4'b1110, S0, 1'b1}) begin
      errors++;
      $display("FAIL zero_dig0_on: got %b/%b/%b want 1110/%b/1", an, seg, dp, S0);
    end
  endtask

  task automatic test_flash();
`ifdef CLOCK_DISP_FLASH_EN
    goto(192);
    vectors++;
    if ({an, seg} !== {4'b0111, SB}) begin
      errors++;
      $display("FAIL flash_on_end: got %b/%b want 0111/1111111", an, seg);
    end
    for (int t = 193; t <= 256; t++) begin
      goto(t);
      vectors++;
      if (an !== 4'b1111) begin
        errors++;
        $display("FAIL flash_off k=%0d: got an=%b want 1111", k, an);
      end
    end
`else
    goto(195);
    vectors++;
    if ({an, seg, dp} !== {4'b1110, S0, 1'b1}) begin
      errors++;
      $display("FAIL steady_dig0: got %b/%b/%b want 1110/%b/1", an, seg, dp, S0);
    end
    goto(211);
    vectors++;
    if ({an, seg, dp} !== {4'b1011, S0, 1'b0}) begin
      errors++;
      $display("FAIL steady_dig2: got %b/%b/%b want 1011/%b/0", an, seg, dp, S0);
    end
`endif
    goto(259);
    vectors++;
    if ({an, seg, dp, time_up} !== {4'b1110, S0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL zero_phase_on: got %b/%b/%b/%b want 1110/%b/1/1", an, seg, dp, time_up, S0);
    end
  endtask

  task automatic test_reset_mid_slot();
    goto(275);
    vectors++;
    if ({an, seg, dp} !== {4'b1011, S0, 1'b0}) begin
      errors++;
      $display("FAIL pre_reset_dig2: got %b/%b/%b want 1011/%b/0", an, seg, dp, S0);
    end
    reset = 1'b1; m = 32'd5; s10 = 32'd4; s1 = 32'd9;
    tick();
    vectors++;
    if ({an, seg, dp, time_up} !== {4'b1111, SB, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: got %b/%b/%b/%b want 1111/1111111/1/0", an, seg, dp, time_up);
    end
    reset = 1'b0;
    k = 0;
    goto(2);
    vectors++;
    if (an !== 4'b1111) begin
      errors++;
      $display("FAIL rerelease_blank: got an=%b want 1111", an);
    end
    goto(3);
    vectors++;
    if ({an, seg, dp, time_up} !== {4'b1110, S9, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rerelease_dig0: got %b/%b/%b/%b want 1110/%b/1/0", an, seg, dp, time_up, S9);
    end
    goto(19);
    vectors++;
    if ({an, seg, dp} !== {4'b1011, S5, 1'b0}) begin
      errors++;
      $display("FAIL rerelease_dig2: got %b/%b/%b want 1011/%b/0", an, seg, dp, S5);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mid_frame_hold();
    test_range();
    test_high_bits();
    test_time_up();
    test_flash();
    test_reset_mid_slot();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
